rssi_gain_comp_mc: RTL and testbench

//  Multi-channel RSSI with gain compensation for the xpu receive path. Takes per-channel half-dB IQ power

---
 rtl/rssi_gain_comp_mc.sv | 163 ++++++++++++++++
 tb/tb_rssi_gain_comp_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rssi_gain_comp_mc.sv
// Multi-channel RSSI with gain compensation: delays per-channel gain words to
// line up with IQ power, forms clamped RSSI, picks the strongest channel, snapshots.
module rssi_gain_comp_mc #(
  parameter int NUM_CH                = 2,
  parameter int GPIO_STATUS_WIDTH     = 8,
  parameter int GAIN_BITS             = 7,
  parameter int DELAY_CTL_WIDTH       = 7,
  parameter int IQ_RSSI_HALF_DB_WIDTH = 9,
  parameter int RSSI_HALF_DB_WIDTH    = 11,
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [DELAY_CTL_WIDTH-1:0]              delay_ctl,
  input  logic [NUM_CH*RSSI_HALF_DB_WIDTH-1:0]    rssi_half_db_offset,
  input  logic [NUM_CH*IQ_RSSI_HALF_DB_WIDTH-1:0] iq_rssi_half_db,
  input  logic                                    iq_rssi_half_db_valid,
  input  logic [NUM_CH*GPIO_STATUS_WIDTH-1:0]     gpio_status,
  input  logic                                    pkt_header_valid_strobe,
  output logic [NUM_CH*RSSI_HALF_DB_WIDTH-1:0]    rssi_half_db,
  output logic                                    rssi_half_db_valid,
  output logic [CH_IDX_W-1:0]                     best_ch,
  output logic [RSSI_HALF_DB_WIDTH-1:0]           best_rssi_half_db,
  output logic                                    best_valid,
  output logic [NUM_CH*RSSI_HALF_DB_WIDTH-1:0]    rssi_lock,
  output logic [NUM_CH*GPIO_STATUS_WIDTH-1:0]     gpio_status_lock,
  output logic [CH_IDX_W-1:0]                     best_ch_lock,
  output logic                                    lock_valid
);

  localparam int W     = RSSI_HALF_DB_WIDTH;
  localparam int IW    = IQ_RSSI_HALF_DB_WIDTH;
  localparam int GW    = GAIN_BITS;
  localparam int GSW   = GPIO_STATUS_WIDTH;
  localparam int DCW   = DELAY_CTL_WIDTH;
  localparam int SW    = W + 2;
  localparam int DEPTH = 2 ** DCW;

  localparam logic [DCW-1:0] CNT_MAX = '1;
  localparam logic signed [SW-1:0] SAT_HI = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {3'b111, {(W-1){1'b0}}};

  logic [NUM_CH*GW-1:0] gain_in;
  logic [NUM_CH*GW-1:0] gain_sel;
  logic [NUM_CH*GW-1:0] gain_s1;
  logic [NUM_CH*IW-1:0] iq_s1;
  logic [NUM_CH*GW-1:0] dline [DEPTH];
  logic [DCW-1:0]       wr_ptr;
  logic [DCW-1:0]       rd_ptr;
  logic [DCW-1:0]       d_q;
  logic [DCW-1:0]       prime_cnt;
  logic [DCW-1:0]       cnt_eff;
  logic                 fire;
  logic                 v1;
  logic                 seen;
  logic [NUM_CH*W-1:0]  rssi_nxt;
  logic [CH_IDX_W-1:0]  bi;
  logic [W-1:0]         bv;

  always_comb begin
    gain_in = '0;
    for (int c = 0; c < NUM_CH; c++)
      gain_in[c*GW +: GW] = gpio_status[c*GSW +: GW];
  end

  // Gain history; only written, never reset
  always_ff @(posedge clk) begin
    if (iq_rssi_half_db_valid)
      dline[wr_ptr] <= gain_in;
  end

  assign rd_ptr   = wr_ptr - delay_ctl;
  assign gain_sel = (delay_ctl == '0) ? gain_in : dline[rd_ptr];

  // A delay change restarts priming from this very cycle
  assign cnt_eff = (delay_ctl != d_q) ? '0 : prime_cnt;
  assign fire    = iq_rssi_half_db_valid && (cnt_eff >= delay_ctl);

  function automatic logic [W-1:0] comp(
    input logic [W-1:0]  off,
    input logic [IW-1:0] iq,
    input logic [GW-1:0] g
  );
    logic signed [SW-1:0] s;
    s = SW'($signed(off)) + SW'($signed(iq))
      - $signed({{(SW-GW-1){1'b0}}, g, 1'b0});
    if (s > SAT_HI)
      s = SAT_HI;
    else if (s < SAT_LO)
      s = SAT_LO;
    return s[W-1:0];
  endfunction

  always_comb begin
    rssi_nxt = '0;
    for (int c = 0; c < NUM_CH; c++)
      rssi_nxt[c*W +: W] = comp(rssi_half_db_offset[c*W +: W],
                                iq_s1[c*IW +: IW],
                                gain_s1[c*GW +: GW]);
  end

  // Strict compare keeps the lowest index on ties
  always_comb begin
    bi = '0;
    bv = rssi_half_db[W-1:0];
    for (int c = 1; c < NUM_CH; c++) begin
      if ($signed(rssi_half_db[c*W +: W]) > $signed(bv)) begin
        bv = rssi_half_db[c*W +: W];
        bi = CH_IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr             <= '0;
      d_q                <= '0;
      prime_cnt          <= '0;
      v1                 <= 1'b0;
      iq_s1              <= '0;
      gain_s1            <= '0;
      rssi_half_db       <= '0;
      rssi_half_db_valid <= 1'b0;
      best_ch            <= '0;
      best_rssi_half_db  <= '0;
      best_valid         <= 1'b0;
      seen               <= 1'b0;
      rssi_lock          <= '0;
      gpio_status_lock   <= '0;
      best_ch_lock       <= '0;
      lock_valid         <= 1'b0;
    end else begin
      d_q <= delay_ctl;
      if (iq_rssi_half_db_valid) begin
        wr_ptr    <= wr_ptr + 1'b1;
        prime_cnt <= (cnt_eff == CNT_MAX) ? CNT_MAX : cnt_eff + 1'b1;
      end else begin
        prime_cnt <= cnt_eff;
      end
      v1 <= fire;
      if (fire) begin
        iq_s1   <= iq_rssi_half_db;
        gain_s1 <= gain_sel;
      end
      rssi_half_db_valid <= v1;
      if (v1)
        rssi_half_db <= rssi_nxt;
      best_valid <= rssi_half_db_valid;
      if (rssi_half_db_valid) begin
        best_ch           <= bi;
        best_rssi_half_db <= bv;
        seen              <= 1'b1;
      end
      if (pkt_header_valid_strobe && (seen || rssi_half_db_valid)) begin
        rssi_lock        <= rssi_half_db;
        gpio_status_lock <= gpio_status;
        best_ch_lock     <= best_ch;
        lock_valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rssi_gain_comp_mc.sv
// Scoreboard bench for rssi_gain_comp_mc: random and directed samples
// checked against a gain-history model of the compensation rules.
module tb_rssi_gain_comp_mc;

  localparam int NC  = 2;
  localparam int W   = 11;
  localparam int IW  = 9;
  localparam int GSW = 8;
  localparam int GB  = 7;
  localparam int DCW = 7;
  localparam int OFV = NC * W;
  localparam int IQV = NC * IW;
  localparam int GPV = NC * GSW;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [DCW-1:0] delay_ctl = '0;
  logic [OFV-1:0] off_v = '0;
  logic [IQV-1:0] iq_v = '0;
  logic           iq_valid = 1'b0;
  logic [GPV-1:0] gpio_v = '0;
  logic           strobe = 1'b0;

  logic [OFV-1:0] rssi_half_db;
  logic           rssi_half_db_valid;
  logic [0:0]     best_ch;
  logic [W-1:0]   best_rssi_half_db;
  logic           best_valid;
  logic [OFV-1:0] rssi_lock;
  logic [GPV-1:0] gpio_status_lock;
  logic [0:0]     best_ch_lock;
  logic           lock_valid;

  rssi_gain_comp_mc dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .delay_ctl               (delay_ctl),
    .rssi_half_db_offset     (off_v),
    .iq_rssi_half_db         (iq_v),
    .iq_rssi_half_db_valid   (iq_valid),
    .gpio_status             (gpio_v),
    .pkt_header_valid_strobe (strobe),
    .rssi_half_db            (rssi_half_db),
    .rssi_half_db_valid      (rssi_half_db_valid),
    .best_ch                 (best_ch),
    .best_rssi_half_db       (best_rssi_half_db),
    .best_valid              (best_valid),
    .rssi_lock               (rssi_lock),
    .gpio_status_lock        (gpio_status_lock),
    .best_ch_lock            (best_ch_lock),
    .lock_valid              (lock_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [OFV-1:0] r;
    int             cyc;
  } rexp_t;

  typedef struct {
    logic [0:0]   ch;
    logic [W-1:0] v;
    int           cyc;
  } bexp_t;

  rexp_t          rq[$];
  bexp_t          bq[$];
  logic [GPV-1:0] hist[$];
  int             mcnt = 0;
  int             mprev = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int sx(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic int ref_rssi(input int off, input int iq, input int g);
    int s;
    s = off + iq - 2 * g;
    if (s > 1023) s = 1023;
    if (s < -1024) s = -1024;
    return s;
  endfunction

  function automatic logic [IQV-1:0] piq(input int a, input int b);
    return {b[IW-1:0], a[IW-1:0]};
  endfunction

  function automatic logic [GPV-1:0] pg(input int a, input int b);
    return {b[GSW-1:0], a[GSW-1:0]};
  endfunction

  function automatic logic [OFV-1:0] poff(input int a, input int b);
    return {b[W-1:0], a[W-1:0]};
  endfunction

  // Reference: gain of sample k is the gain word seen with sample k-d;
  // a sample yields output only once d valids have passed since (re)priming.
  task automatic model_step();
    int d, cnt, k, rv, bvv, bch, off, iq, g;
    logic [OFV-1:0] rp;
    rexp_t re;
    bexp_t be;
    d   = int'(delay_ctl);
    cnt = (d != mprev) ? 0 : mcnt;
    mprev = d;
    if (iq_valid) begin
      hist.push_back(gpio_v);
      k = hist.size() - 1;
      if (cnt >= d) begin
        rp  = '0;
        bvv = -100000;
        bch = 0;
        for (int c = 0; c < NC; c++) begin
          off = sx(int'(off_v[c*W +: W]), W);
          iq  = sx(int'(iq_v[c*IW +: IW]), IW);
          g   = int'(hist[k-d][c*GSW +: GB]);
          rv  = ref_rssi(off, iq, g);
          rp[c*W +: W] = rv[W-1:0];
          if (rv > bvv) begin
            bvv = rv;
            bch = c;
          end
        end
        re.r   = rp;
        re.cyc = cyc + 2;
        rq.push_back(re);
        be.ch  = bch[0:0];
        be.v   = bvv[W-1:0];
        be.cyc = cyc + 3;
        bq.push_back(be);
      end
      mcnt = (cnt == 127) ? 127 : cnt + 1;
    end else begin
      mcnt = cnt;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IQV-1:0] iq, input logic [GPV-1:0] g);
    iq_valid = 1'b1;
    iq_v     = iq;
    gpio_v   = g;
    tick();
    iq_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    iq_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    iq_valid = 1'b0;
    strobe   = 1'b0;
    @(posedge clk);
    #1;
    rq.delete();
    bq.delete();
    hist.delete();
    mcnt  = 0;
    mprev = 0;
    repeat (2) begin
      chk("reset_out_a", 128'({rssi_half_db, rssi_half_db_valid, best_ch,
                               best_rssi_half_db, best_valid}), 128'(0));
      chk("reset_out_b", 128'({rssi_lock, gpio_status_lock, best_ch_lock,
                               lock_valid}), 128'(0));
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rssi_half_db_valid) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rssi_unexpected actual=%0h expected=none cyc=%0d",
                 rssi_half_db, cyc);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        chk("rssi", 128'(rssi_half_db), 128'(e.r));
        chk("rssi_latency", 128'(cyc), 128'(e.cyc));
      end
    end
    if (best_valid) begin
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL best_unexpected actual=%0h expected=none cyc=%0d",
                 best_rssi_half_db, cyc);
      end else begin
        bexp_t e;
        e = bq.pop_front();
        chk("best_ch", 128'(best_ch), 128'(e.ch));
        chk("best_rssi", 128'(best_rssi_half_db), 128'(e.v));
        chk("best_latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    int dtab[6];
    int n;
    dtab = '{1, 0, 2, 7, 127, 4};

    do_reset();

    // Snapshot request before any output is ignored
    strobe = 1'b1;
    idle(1);
    strobe = 1'b0;
    idle(3);
    chk("lock_early", 128'(lock_valid), 128'(0));

    // d=0 reference case, then a snapshot taken on an S2 update
    send(piq(100, 60), pg(10, 5));
    idle(6);
    send(piq(20, 90), pg(0, 0));
    gpio_v = 16'hA55A;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    idle(6);
    chk("lock_valid", 128'(lock_valid), 128'(1));
    chk("lock_rssi_pre", 128'(rssi_lock), 128'(poff(80, 50)));
    chk("lock_best_pre", 128'(best_ch_lock), 128'(0));
    chk("lock_gpio", 128'(gpio_status_lock), 128'(16'hA55A));
    gpio_v = 16'h1234;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    idle(2);
    chk("lock_rssi_new", 128'(rssi_lock), 128'(poff(20, 90)));
    chk("lock_best_new", 128'(best_ch_lock), 128'(1));
    chk("lock_gpio_new", 128'(gpio_status_lock), 128'(16'h1234));

    // Ties and near-ties
    send(piq(50, 50), pg(0, 0));
    send(piq(50, 51), pg(0, 0));
    idle(5);

    // Saturation both ways on both channels
    off_v = poff(1000, -1024);
    send(piq(255, -256), pg(0, 127));
    idle(5);
    off_v = poff(-1024, 1000);
    send(piq(-256, 255), pg(127, 0));
    idle(5);
    off_v = '0;
    idle(2);

    // d=3 with a gain step after five samples
    delay_ctl = 3;
    for (int i = 0; i < 12; i++)
      send(piq(100, 100), pg((i < 5) ? 10 : 20, 0));
    idle(5);

    // Delay change 3 -> 5 in a back-to-back stream
    for (int i = 0; i < 8; i++)
      send(IQV'($urandom), GPV'($urandom));
    delay_ctl = 5;
    for (int i = 0; i < 10; i++)
      send(IQV'($urandom), GPV'($urandom));
    idle(5);

    // Random phases
    for (int ph = 0; ph < 6; ph++) begin
      delay_ctl = DCW'(dtab[ph]);
      off_v     = OFV'($urandom);
      n         = (dtab[ph] == 127) ? 300 : 120;
      for (int i = 0; i < n; i++) begin
        iq_valid = ($urandom_range(0, 9) < 7);
        iq_v     = IQV'($urandom);
        gpio_v   = GPV'($urandom);
        if ($urandom_range(0, 59) == 0)
          delay_ctl = DCW'($urandom_range(0, 7));
        tick();
      end
      idle(6);
    end

    // Reset in the middle of a burst
    off_v     = '0;
    delay_ctl = 0;
    idle(2);
    for (int i = 0; i < 4; i++)
      send(IQV'($urandom), GPV'($urandom));
    do_reset();
    chk("lock_after_reset", 128'(lock_valid), 128'(0));
    strobe = 1'b1;
    idle(1);
    strobe = 1'b0;
    idle(2);
    chk("lock_after_reset_strobe", 128'(lock_valid), 128'(0));

    // Re-prime from zero after reset
    delay_ctl = 2;
    for (int i = 0; i < 20; i++)
      send(IQV'($urandom), GPV'($urandom));
    idle(8);

    chk("rssi_queue_drained", 128'(rq.size()), 128'(0));
    chk("best_queue_drained", 128'(bq.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
